// File: rtl/dekatron_pkg.sv
// Shared definitions for the Dekatron chain sequencer: op codes, FSM states
// and one-hot digit helpers.
package dekatron_pkg;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [9:0] ONE_HOT_ZERO = 10'b0000000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_STEP,
        ST_SETTLE,
        ST_CHECK,
        ST_LOAD,
        ST_LWAIT,
        ST_DONE
    } state_t;

    function automatic logic onehot_valid(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    function automatic logic [9:0] rot_inc(input logic [9:0] v);
        return {v[8:0], v[9]};
    endfunction

    function automatic logic [9:0] rot_dec(input logic [9:0] v);
        return {v[0], v[9:1]};
    endfunction

endpackage

// File: rtl/dekatron_strobe_gen.sv
// Emits PULSES_PER_COUNT one-cycle strobes, each followed by STEP_GAP idle
// cycles; last flags the final gap cycle (or the final strobe when STEP_GAP=0).
module dekatron_strobe_gen #(
    parameter int PULSES_PER_COUNT = 3,
    parameter int STEP_GAP         = 1
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic start,
    output logic strobe,
    output logic busy,
    output logic last
);

    localparam int PW = (STEP_GAP > 0) ? $clog2(STEP_GAP + 1) : 1;
    localparam int CW = (PULSES_PER_COUNT > 1) ? $clog2(PULSES_PER_COUNT) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(STEP_GAP);
    localparam logic [CW-1:0] PU_LAST = CW'(PULSES_PER_COUNT - 1);

    logic [PW-1:0] phase;
    logic [CW-1:0] pulse;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy  <= 1'b0;
            phase <= '0;
            pulse <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            phase <= '0;
            pulse <= '0;
        end else if (busy) begin
            if (phase == PH_LAST) begin
                phase <= '0;
                if (pulse == PU_LAST) begin
                    busy <= 1'b0;
                end else begin
                    pulse <= pulse + CW'(1);
                end
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

    assign strobe = busy && (phase == '0);
    assign last   = busy && (phase == PH_LAST) && (pulse == PU_LAST);

endmodule

// File: rtl/dekatron_chain_sequencer.sv
// Sequences INC/DEC/CLR over a chain of one-hot Dekatron digits, rippling
// carry/borrow digit by digit and verifying every digit's result.
module dekatron_chain_sequencer
    import dekatron_pkg::*;
#(
    parameter int DIGITS           = 3,
    parameter int PULSES_PER_COUNT = 3,
    parameter int STEP_GAP         = 1,
    parameter int READY_TIMEOUT    = 15
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Req,
    input  logic [1:0]             Op,
    output logic                   ReqReady,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Carry,
    output logic                   Fault,
    output logic [DIGITS-1:0]      DigStep,
    output logic [DIGITS-1:0]      DigEn,
    output logic                   DigReverse,
    output logic                   DigSet,
    output logic [9:0]             DigIn,
    input  logic [DIGITS-1:0]      DigReady,
    input  logic [DIGITS*10-1:0]   DigOut
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = $clog2(READY_TIMEOUT + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(READY_TIMEOUT - 1);

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [1:0]    op_q;
    logic [9:0]    prev_q;
    logic          carry_q, fault_q;
    logic [TW-1:0] tmo_cnt;
    logic          set_fault, clr_fault, set_carry;
    logic          sg_start, sg_strobe, sg_busy, sg_last;

    logic [9:0]        dig_arr [DIGITS];
    logic [9:0]        dig_sel, exp_val;
    logic              ripple, all_zero;
    logic [DIGITS-1:0] step_mask;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        assign dig_arr[k] = DigOut[10*k +: 10];
    end

    always_comb begin
        all_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_arr[k] != ONE_HOT_ZERO) all_zero = 1'b0;
        end
    end

    assign dig_sel   = dig_arr[idx];
    assign exp_val   = (op_q == OP_DEC) ? rot_dec(prev_q) : rot_inc(prev_q);
    assign ripple    = (op_q == OP_DEC) ? prev_q[0] : prev_q[9];
    assign step_mask = DIGITS'(1) << idx;

    dekatron_strobe_gen #(
        .PULSES_PER_COUNT (PULSES_PER_COUNT),
        .STEP_GAP         (STEP_GAP)
    ) u_strobe (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .start  (sg_start),
        .strobe (sg_strobe),
        .busy   (sg_busy),
        .last   (sg_last)
    );

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        set_fault = 1'b0;
        clr_fault = 1'b0;
        set_carry = 1'b0;
        sg_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Req) begin
                    case (Op)
                        OP_INC, OP_DEC: begin
                            state_nx = ST_CAPTURE;
                            idx_nx   = '0;
                        end
                        OP_CLR: begin
                            state_nx  = ST_LOAD;
                            clr_fault = 1'b1;
                        end
                        default: state_nx = ST_DONE;
                    endcase
                end
            end
            ST_CAPTURE: begin
                if (!onehot_valid(dig_sel)) begin
                    set_fault = 1'b1;
                    state_nx  = ST_DONE;
                end else begin
                    sg_start = 1'b1;
                    state_nx = ST_STEP;
                end
            end
            ST_STEP: begin
                if (sg_last) state_nx = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (DigReady[idx]) begin
                    state_nx = ST_CHECK;
                end else if (tmo_cnt == TMO_LAST) begin
                    set_fault = 1'b1;
                    state_nx  = ST_DONE;
                end
            end
            ST_CHECK: begin
                if (dig_sel != exp_val) begin
                    set_fault = 1'b1;
                    state_nx  = ST_DONE;
                end else if (ripple && (idx != IDX_LAST)) begin
                    idx_nx   = idx + IW'(1);
                    state_nx = ST_CAPTURE;
                end else begin
                    set_carry = ripple;
                    state_nx  = ST_DONE;
                end
            end
            ST_LOAD: state_nx = ST_LWAIT;
            ST_LWAIT: begin
                if (&DigReady) begin
                    set_fault = !all_zero;
                    state_nx  = ST_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    set_fault = 1'b1;
                    state_nx  = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            op_q    <= OP_INC;
            carry_q <= 1'b0;
            fault_q <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (state == ST_IDLE && Req) op_q <= Op;
            if (state == ST_IDLE)  carry_q <= 1'b0;
            else if (set_carry)    carry_q <= 1'b1;
            if (clr_fault)         fault_q <= 1'b0;
            else if (set_fault)    fault_q <= 1'b1;
            // Ready-timeout counter runs only while waiting on a digit
            if (state == ST_SETTLE || state == ST_LWAIT) tmo_cnt <= tmo_cnt + TW'(1);
            else                                         tmo_cnt <= '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (state == ST_CAPTURE) prev_q <= dig_sel;
    end

    assign ReqReady   = (state == ST_IDLE);
    assign Busy       = (state != ST_IDLE);
    assign Done       = (state == ST_DONE);
    assign Carry      = (state == ST_DONE) && carry_q;
    assign Fault      = fault_q;
    assign DigReverse = (state == ST_STEP) && (op_q == OP_DEC);
    assign DigSet     = (state == ST_LOAD);
    assign DigIn      = ONE_HOT_ZERO;
    assign DigEn      = (state == ST_STEP && sg_busy) ? step_mask :
                        (state == ST_LOAD)            ? '1 : '0;
    assign DigStep    = (state == ST_STEP && sg_strobe) ? step_mask :
                        (state == ST_LOAD)              ? '1 : '0;

endmodule

// File: tb/tb_dekatron_chain_sequencer.sv
// Bench for dekatron_chain_sequencer: behavioural three-digit Dekatron chain,
// directed operations, and a Done-driven scoreboard monitor.
module tb_dekatron_chain_sequencer;

    localparam int D = 3;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Req = 1'b0;
    logic [1:0]    Op = 2'b00;
    logic          ReqReady, Busy, Done, Carry, Fault, DigReverse, DigSet;
    logic [D-1:0]  DigStep, DigEn, DigReady;
    logic [9:0]    DigIn;
    logic [D*10-1:0] DigOut;

    dekatron_chain_sequencer #(
        .DIGITS(D), .PULSES_PER_COUNT(3), .STEP_GAP(1), .READY_TIMEOUT(15)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Op(Op),
        .ReqReady(ReqReady), .Busy(Busy), .Done(Done), .Carry(Carry), .Fault(Fault),
        .DigStep(DigStep), .DigEn(DigEn), .DigReverse(DigReverse), .DigSet(DigSet),
        .DigIn(DigIn), .DigReady(DigReady), .DigOut(DigOut)
    );

    always #5 Clk = ~Clk;

    // Digit chain model: three strobes per count, optional double-step fault
    logic [9:0]  dval [D];
    int          pcnt [D];
    logic        preset_req = 1'b0;
    logic [29:0] preset_val = '0;
    logic [D-1:0] hold_rdy = '0;
    logic [D-1:0] skip = '0;

    assign DigReady = ~hold_rdy;
    assign DigOut   = {dval[2], dval[1], dval[0]};

    function automatic logic [9:0] mstep(input logic [9:0] v, input logic rev);
        return rev ? {v[0], v[9:1]} : {v[8:0], v[9]};
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < D; k++) begin
                dval[k] <= 10'd1;
                pcnt[k] <= 0;
            end
        end else if (preset_req) begin
            for (int k = 0; k < D; k++) begin
                dval[k] <= preset_val[10*k +: 10];
                pcnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < D; k++) begin
                if (DigEn[k] && DigStep[k]) begin
                    if (DigSet) begin
                        dval[k] <= DigIn;
                        pcnt[k] <= 0;
                    end else if (pcnt[k] == 2) begin
                        pcnt[k] <= 0;
                        dval[k] <= skip[k] ? mstep(mstep(dval[k], DigReverse), DigReverse)
                                           : mstep(dval[k], DigReverse);
                    end else begin
                        pcnt[k] <= pcnt[k] + 1;
                    end
                end
            end
        end
    end

    typedef struct {
        string       name;
        logic        carry;
        logic        fault;
        logic [29:0] val;
        int          lat;
        int          s0, s1, s2;
        logic        rev;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic logic [29:0] v3(input int d2, input int d1, input int d0);
        logic [9:0] one = 10'd1;
        return {one << d2, one << d1, one << d0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic c, input logic f, input logic [29:0] v,
                        input int lat, input int s0, input int s1, input int s2, input logic rev);
        exp_t e;
        e.name = name; e.carry = c; e.fault = f; e.val = v; e.lat = lat;
        e.s0 = s0; e.s1 = s1; e.s2 = s2; e.rev = rev;
        sb.push_back(e);
    endtask

    // Cycle index counts the accept cycle as 1, so Done for a one-digit INC lands on 11
    task automatic monitor();
        int   cyc = 0;
        int   st [D];
        int   stray = 0;
        logic rev_last = 1'b0;
        exp_t e;
        for (int k = 0; k < D; k++) st[k] = 0;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                cyc = 0;
            end else begin
                if (cyc != 0) cyc++;
                if (Req && ReqReady) begin
                    cyc = 1;
                    stray = 0;
                    for (int k = 0; k < D; k++) st[k] = 0;
                end
                if ((DigStep & ~DigEn) != '0) stray++;
                if (!DigSet && $countones(DigEn) > 1) stray++;
                if (DigStep != '0 && !Busy) stray++;
                if (!DigSet) begin
                    for (int k = 0; k < D; k++) begin
                        if (DigStep[k]) begin
                            st[k]++;
                            rev_last = DigReverse;
                        end
                    end
                end
                if (Done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_carry"}, 32'(Carry), 32'(e.carry));
                        check({e.name, "_fault"}, 32'(Fault), 32'(e.fault));
                        check({e.name, "_value"}, 32'(DigOut), 32'(e.val));
                        check({e.name, "_latency"}, 32'(cyc), 32'(e.lat));
                        check({e.name, "_strobes0"}, 32'(st[0]), 32'(e.s0));
                        check({e.name, "_strobes1"}, 32'(st[1]), 32'(e.s1));
                        check({e.name, "_strobes2"}, 32'(st[2]), 32'(e.s2));
                        check({e.name, "_stray"}, 32'(stray), 32'd0);
                        if (e.s0 + e.s1 + e.s2 > 0)
                            check({e.name, "_reverse"}, 32'(rev_last), 32'(e.rev));
                    end
                    cyc = 0;
                end
            end
        end
    endtask

    task automatic preset(input logic [29:0] v);
        @(posedge Clk); #1;
        preset_val = v;
        preset_req = 1'b1;
        @(posedge Clk); #1;
        preset_req = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op);
        @(posedge Clk); #1;
        Req = 1'b1;
        Op  = op;
        @(posedge Clk); #1;
        Req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (sb.size() == 0 && ReqReady) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_idle_wait"}, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ReqReady"}, 32'(ReqReady), 32'd1);
        check({tag, "_Busy"}, 32'(Busy), 32'd0);
        check({tag, "_Done"}, 32'(Done), 32'd0);
        check({tag, "_Carry"}, 32'(Carry), 32'd0);
        check({tag, "_Fault"}, 32'(Fault), 32'd0);
        check({tag, "_DigStep"}, 32'(DigStep), 32'd0);
        check({tag, "_DigEn"}, 32'(DigEn), 32'd0);
        check({tag, "_DigReverse"}, 32'(DigReverse), 32'd0);
        check({tag, "_DigSet"}, 32'(DigSet), 32'd0);
        check({tag, "_DigIn"}, 32'(DigIn), 32'h001);
    endtask

    initial begin
        logic seen;
        fork
            monitor();
        join_none

        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Rst_n = 1'b1;

        push("inc_000", 1'b0, 1'b0, v3(0, 0, 1), 11, 3, 0, 0, 1'b0);
        issue(2'b00);
        wait_idle("inc_000");

        preset(v3(0, 9, 9));
        push("inc_099", 1'b0, 1'b0, v3(1, 0, 0), 29, 3, 3, 3, 1'b0);
        issue(2'b00);
        wait_idle("inc_099");

        preset(v3(9, 9, 9));
        push("inc_999", 1'b1, 1'b0, v3(0, 0, 0), 29, 3, 3, 3, 1'b0);
        issue(2'b00);
        wait_idle("inc_999");
        check("carry_clears_idle", 32'(Carry), 32'd0);

        push("dec_000", 1'b1, 1'b0, v3(9, 9, 9), 29, 3, 3, 3, 1'b1);
        issue(2'b01);
        wait_idle("dec_000");

        preset(v3(0, 0, 5));
        push("dec_005", 1'b0, 1'b0, v3(0, 0, 4), 11, 3, 0, 0, 1'b1);
        issue(2'b01);
        wait_idle("dec_005");

        push("nop", 1'b0, 1'b0, v3(0, 0, 4), 2, 0, 0, 0, 1'b0);
        issue(2'b11);
        wait_idle("nop");

        preset(v3(0, 0, 0));
        hold_rdy = 3'b001;
        push("ready_timeout", 1'b0, 1'b1, v3(0, 0, 1), 24, 3, 0, 0, 1'b0);
        issue(2'b00);
        wait_idle("ready_timeout");
        hold_rdy = 3'b000;
        check("fault_sticky", 32'(Fault), 32'd1);

        preset(v3(3, 7, 2));
        push("clr_after_timeout", 1'b0, 1'b0, v3(0, 0, 0), 4, 0, 0, 0, 1'b0);
        issue(2'b10);
        wait_idle("clr_after_timeout");

        preset(v3(0, 0, 9));
        skip = 3'b001;
        push("bad_step", 1'b0, 1'b1, v3(0, 0, 1), 11, 3, 0, 0, 1'b0);
        issue(2'b00);
        repeat (2) @(posedge Clk);
        #1;
        Req = 1'b1;
        Op  = 2'b01;
        repeat (2) @(posedge Clk);
        #1;
        Req = 1'b0;
        wait_idle("bad_step");
        skip = 3'b000;
        repeat (20) @(posedge Clk);
        check("no_second_done", 32'(sb.size()), 32'd0);

        preset(v3(0, 0, 1));
        push("clr_after_bad", 1'b0, 1'b0, v3(0, 0, 0), 4, 0, 0, 0, 1'b0);
        issue(2'b10);
        wait_idle("clr_after_bad");

        issue(2'b00);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (DigStep[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("reached_step", 32'(seen), 32'd1);
        @(posedge Clk); #2;
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("midstep_reset");
        check("midstep_digits", 32'(DigOut), 32'(v3(0, 0, 0)));
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        push("inc_after_reset", 1'b0, 1'b0, v3(0, 0, 1), 11, 3, 0, 0, 1'b0);
        issue(2'b00);
        wait_idle("inc_after_reset");

        repeat (5) @(posedge Clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dekatron_chain_sequencer.md
Name: dekatron_chain_sequencer

Overview:
- Controller that sequences an N-digit decimal counter built from a chain of Dekatron digit units. Each unit holds a one-hot 10-bit value and needs three Step pulses per count.
- Accepts increment, decrement and clear requests from the CPU control path, and drives each digit's step, direction, enable and load lines.
- Ripples carry/borrow digit by digit, and checks each digit's one-hot result.
- Sits between the instruction sequencer and the IP/AP/data dekatron banks.

Parameters:
- DIGITS, 3, number of chained digit units (1..8).
- PULSES_PER_COUNT, 3, Step strobes required for one count (NONE->RIGHT->LEFT->NONE).
- STEP_GAP, 1, idle cycles between consecutive Step strobes.
- READY_TIMEOUT, 15, max cycles to wait for a digit's Ready before faulting.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- Req  in  1  operation request, sampled in IDLE.
- Op  in  2  00 INC, 01 DEC, 10 CLR, 11 reserved.
- ReqReady  out  1  high only in IDLE.
- Busy  out  1  high in any state except IDLE.
- Done  out  1  one-cycle pulse at operation end.
- Carry  out  1  set with Done: INC wrapped past all-9s, or DEC wrapped past all-0s.
- Fault  out  1  sticky; cleared only by reset or by an accepted CLR.
- DigStep  out  DIGITS  one-cycle Step strobe per digit.
- DigEn  out  DIGITS  enable for the digit being stepped.
- DigReverse  out  1  shared direction, 1 = decrement.
- DigSet  out  1  shared load strobe qualifier.
- DigIn  out  10  shared load value.
- DigReady  in  DIGITS  per-digit Ready.
- DigOut  in  DIGITS*10  per-digit one-hot value; digit k is at bits [10k+9:10k].

Behaviour:
- Reset values: every output is 0, except ReqReady=1 and DigIn=10'b0000000001. State is IDLE and the digit index is 0.
- Reset mid-operation aborts at once, with no Done. The digits are reset by the same Rst_n.
- Handshake: a Req with ReqReady=1 is accepted on that edge, and Op is latched. Req while Busy is ignored and not queued.
- States: IDLE, CAPTURE, STEP, SETTLE, CHECK, LOAD, LWAIT, DONE.
- IDLE:
  - INC/DEC -> CAPTURE with idx=0.
  - CLR -> LOAD and clears Fault.
  - Op 11 -> DONE (no-op; Carry=0).
- CAPTURE (1 cycle):
  - Latch Prev = DigOut of digit idx.
  - If Prev is not exactly one-hot, set Fault and go to DONE.
  - Otherwise go to STEP.
- STEP:
  - DigEn[idx]=1 throughout; DigReverse = (Op==DEC).
  - Emit PULSES_PER_COUNT strobes on DigStep[idx]. Each strobe is one cycle high, followed by STEP_GAP low cycles.
  - After the last gap -> SETTLE.
- SETTLE:
  - Wait until DigReady[idx]=1, then go to CHECK.
  - If DigReady is not seen within READY_TIMEOUT cycles, set Fault and go to DONE.
- CHECK (1 cycle):
  - Expected result: Prev rotated left by 1 for INC (bit 9 -> bit 0), or right by 1 for DEC (bit 0 -> bit 9).
  - Mismatch with DigOut -> set Fault, go to DONE.
  - Ripple condition: INC with Prev[9], or DEC with Prev[0].
  - If ripple and idx<DIGITS-1: idx++, go to CAPTURE.
  - If ripple and idx==DIGITS-1: set the Carry latch, go to DONE.
  - No ripple: go to DONE.
- LOAD (1 cycle):
  - DigSet=1, DigIn=10'b0000000001.
  - DigEn all 1, DigStep all 1 for one cycle.
  - Then -> LWAIT.
- LWAIT:
  - Wait for all DigReady=1 and every DigOut==10'b0000000001 (timeout rule as in SETTLE), then go to DONE.
  - A mismatch after Ready is a Fault.
- DONE (1 cycle): Done=1 and Carry presented. Then -> IDLE; Carry clears in IDLE.
- DigEn is 0 for every digit except the one being stepped; DigStep is never high outside STEP or LOAD.
- Latency for INC/DEC without ripple: 1 accept + 1 CAPTURE + P*(1+GAP) + s + 1 CHECK + 1 DONE, where s = SETTLE cycles, P = PULSES_PER_COUNT, GAP = STEP_GAP. With defaults and Ready immediate this is 11 cycles from accept to Done.
- Each extra rippled digit adds CAPTURE..CHECK again.

Decomposition:
- Shared package dekatron_pkg holds:
  - Op codes OP_INC, OP_DEC, OP_CLR, OP_NOP.
  - The state enum.
  - ONE_HOT_ZERO = 10'b0000000001.
  - Function onehot_valid (exactly one bit set).
  - Functions rot_inc and rot_dec (10-bit one-hot rotate).
- One sub-module, dekatron_strobe_gen: a counter generating PULSES_PER_COUNT strobes with STEP_GAP spacing. Its interface is start, busy and last.

Test Plan:
- DIGITS=3, value 000, INC -> 3 strobes on DigStep[0] only, DigReverse=0; digit0 reads 1; Done 11 cycles after accept; Carry=0.
- Value 099, INC -> digits 0, 1, 2 stepped in order (9 strobes total); result 100; Carry=0; no strobes on idle digits.
- Value 999, INC -> result 000 with Carry=1 on the Done cycle. Then value 000, DEC -> result 999, Carry=1, DigReverse=1.
- Hold DigReady[0]=0 after STEP -> Fault rises after 15 SETTLE cycles, Done pulses; a subsequent CLR clears Fault and all digits read 10'b0000000001.
- Force a bad result (digit model skips a position) -> Fault in CHECK, no ripple. Req asserted while Busy -> ignored, no second Done.
- Assert Rst_n low mid-STEP -> all outputs at reset values asynchronously, no Done; after release ReqReady=1 and an INC works normally.
